// File: rtl/modulo_varredura_matriz.sv
// -----------------------------------------------------------------------------
// modulo_varredura_matriz
//
// Row-scan driver for the 5x7 dot-matrix display. Once per frame the 35-bit
// pattern is latched into a shadow register, then the seven rows are driven
// one at a time, each for DIV cycles, with BLANK dark cycles at the start of
// every row slot to suppress ghosting.
//
// Parameters:
//   DIV   - clock cycles per row slot (>= 2, > BLANK)
//   BLANK - dark cycles at the start of each row slot (>= 0)
//
// Ports:
//   CLK         in   system clock, rising edge
//   RST_N       in   asynchronous active-low reset
//   EN          in   scan enable; 0 blanks the display and halts scanning
//   PAT[34:0]   in   frame pattern, row r is PAT[5r+4:5r], 1 = LED on
//   ROW[6:0]    out  row select, active-low one-hot, all-ones = no row
//   COL[4:0]    out  column data, active-high
//   ROW_IDX[2:0] out index of the current row slot, 0..6
//   FRAME_START out  one-cycle pulse during the LOAD cycle
//
// All outputs are registered: the output registers are loaded from the
// *next* state values, so what is visible after an edge always matches the
// state entered on that edge.
// -----------------------------------------------------------------------------
module modulo_varredura_matriz #(
  parameter int DIV   = 50000,
  parameter int BLANK = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN,
  input  logic [34:0] PAT,
  output logic [6:0]  ROW,
  output logic [4:0]  COL,
  output logic [2:0]  ROW_IDX,
  output logic        FRAME_START
);

  localparam int CW = $clog2(DIV);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    row_idx, row_idx_d;
  logic [34:0]   shadow, shadow_d;
  logic [6:0]    row_d;
  logic [4:0]    col_d;
  logic          frame_start_d;
  logic          in_blank;

  // The blank window is evaluated against the next counter value so the
  // registered outputs line up with the slot position entered on the edge.
  generate
    if (BLANK == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt_d < CW'(BLANK));
    end
  endgenerate

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state;
    cnt_d         = cnt;
    row_idx_d     = row_idx;
    shadow_d      = shadow;
    row_d         = 7'h7F;
    col_d         = 5'b00000;
    frame_start_d = 1'b0;

    case (state)
      IDLE: begin
        cnt_d     = '0;
        row_idx_d = 3'd0;
        if (EN) state_d = LOAD;
      end
      LOAD: begin
        shadow_d  = PAT;
        cnt_d     = '0;
        row_idx_d = 3'd0;
        state_d   = SCAN;
      end
      SCAN: begin
        if (cnt == CW'(DIV - 1)) begin
          cnt_d = '0;
          if (row_idx == 3'd6) begin
            row_idx_d = 3'd0;
            state_d   = LOAD;
          end else begin
            row_idx_d = row_idx + 3'd1;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Dropping EN overrides everything: no resume mid-frame, the next
    // enable always restarts with a fresh LOAD.
    if (!EN) begin
      state_d   = IDLE;
      cnt_d     = '0;
      row_idx_d = 3'd0;
    end

    frame_start_d = (state_d == LOAD);
    if ((state_d == SCAN) && !in_blank) begin
      row_d = ~(7'b0000001 << row_idx_d);
      case (row_idx_d)
        3'd0:    col_d = shadow_d[4:0];
        3'd1:    col_d = shadow_d[9:5];
        3'd2:    col_d = shadow_d[14:10];
        3'd3:    col_d = shadow_d[19:15];
        3'd4:    col_d = shadow_d[24:20];
        3'd5:    col_d = shadow_d[29:25];
        3'd6:    col_d = shadow_d[34:30];
        default: col_d = 5'b00000;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      cnt         <= '0;
      row_idx     <= 3'd0;
      shadow      <= '0;
      ROW         <= 7'h7F;
      COL         <= 5'b00000;
      FRAME_START <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      row_idx     <= row_idx_d;
      shadow      <= shadow_d;
      ROW         <= row_d;
      COL         <= col_d;
      FRAME_START <= frame_start_d;
    end
  end

  assign ROW_IDX = row_idx;

endmodule

// File: tb/tb_modulo_varredura_matriz.sv
// -----------------------------------------------------------------------------
// tb_modulo_varredura_matriz
//
// Two instances: u_a (DIV=4, BLANK=1) and u_b (DIV=2, BLANK=0). A frame
// position model predicts every output each cycle; predictions are queued at
// the rising edge and compared at the following falling edge. A short table
// of hand-derived vectors covers the start of the first frame, and targeted
// sequences cover period, tearing, enable drop, reset and zero blanking.
// -----------------------------------------------------------------------------
module tb_modulo_varredura_matriz;

  localparam int DIV_A   = 4;
  localparam int BLANK_A = 1;
  localparam int DIV_B   = 2;
  localparam int BLANK_B = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic [34:0] pat_a = '0, pat_b = '0;
  logic [6:0]  row_a, row_b;
  logic [4:0]  col_a, col_b;
  logic [2:0]  idx_a, idx_b;
  logic        fs_a, fs_b;

  always #5 clk = ~clk;

  modulo_varredura_matriz #(.DIV(DIV_A), .BLANK(BLANK_A)) u_a (
    .CLK(clk), .RST_N(rst_n), .EN(en_a), .PAT(pat_a),
    .ROW(row_a), .COL(col_a), .ROW_IDX(idx_a), .FRAME_START(fs_a)
  );

  modulo_varredura_matriz #(.DIV(DIV_B), .BLANK(BLANK_B)) u_b (
    .CLK(clk), .RST_N(rst_n), .EN(en_b), .PAT(pat_b),
    .ROW(row_b), .COL(col_b), .ROW_IDX(idx_b), .FRAME_START(fs_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // p = 0 is the LOAD cycle, p = 1..7*div are the scan cycles of a frame.
  typedef struct {
    bit          idle;
    int          p;
    logic [34:0] sh;
    int          div;
    int          blank;
  } model_t;

  typedef struct {
    int         dut;
    logic [6:0] row;
    logic [4:0] col;
    logic [2:0] idx;
    logic       fs;
    bit         chk_idx;
  } exp_t;

  model_t m[2];
  exp_t   sb[$];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m[d].idle = 1'b1;
      m[d].p    = 0;
      m[d].sh   = '0;
    end
    m[0].div = DIV_A; m[0].blank = BLANK_A;
    m[1].div = DIV_B; m[1].blank = BLANK_B;
  endtask

  function automatic void model_step(input int d, input logic en, input logic [34:0] pat);
    if (!en)                 m[d].idle = 1'b1;
    else if (m[d].idle) begin m[d].idle = 1'b0; m[d].p = 0; end
    else if (m[d].p == 0) begin m[d].sh = pat; m[d].p = 1; end
    else                     m[d].p = (m[d].p == 7 * m[d].div) ? 0 : m[d].p + 1;
  endfunction

  function automatic exp_t predict(input int d);
    exp_t e;
    int   slot, off;
    e.dut = d; e.row = 7'h7F; e.col = 5'h00; e.idx = 3'd0; e.fs = 1'b0; e.chk_idx = 1'b1;
    if (!m[d].idle) begin
      if (m[d].p == 0) begin
        e.fs      = 1'b1;
        e.chk_idx = 1'b0;
      end else begin
        slot  = (m[d].p - 1) / m[d].div;
        off   = (m[d].p - 1) % m[d].div;
        e.idx = 3'(slot);
        if (off >= m[d].blank) begin
          e.row = ~(7'b0000001 << slot);
          e.col = 5'(m[d].sh >> (5 * slot));
        end
      end
    end
    return e;
  endfunction

  task automatic compare_out(input string tag, input exp_t e, input logic [6:0] row,
                             input logic [4:0] col, input logic [2:0] idx, input logic fs);
    check({tag, "_row"}, row, e.row);
    check({tag, "_col"}, col, e.col);
    check({tag, "_fs"},  fs,  e.fs);
    if (e.chk_idx) check({tag, "_idx"}, idx, e.idx);
  endtask

  // One clock: model advances with the DUTs at the rising edge, predictions
  // are queued, then popped and compared at the falling edge.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    model_step(0, en_a, pat_a);
    model_step(1, en_b, pat_b);
    sb.push_back(predict(0));
    sb.push_back(predict(1));
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.dut == 0) compare_out("sb_a", e, row_a, col_a, idx_a, fs_a);
      else            compare_out("sb_b", e, row_b, col_b, idx_b, fs_b);
    end
  endtask

  // ---------------- continuous one-hot / index check ----------------
  function automatic bit row_ok(input logic [6:0] r);
    return (r == 7'h7F) || ($countones(~r) == 1);
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("onehot_a", {31'd0, row_ok(row_a)}, 32'd1);
      check("onehot_b", {31'd0, row_ok(row_b)}, 32'd1);
      check("idx_range_a", {31'd0, (idx_a <= 3'd6)}, 32'd1);
      check("idx_range_b", {31'd0, (idx_b <= 3'd6)}, 32'd1);
    end
  end

  // ---------------- hand-derived start-of-frame vectors ----------------
  typedef struct {
    logic       en;
    logic [6:0] row;
    logic [4:0] col;
    logic       fs;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [34:0] pat_frame;
    int          since;
    int          blanks;

    tbl[0]  = '{1'b1, 7'h7F, 5'h00, 1'b1};  // LOAD
    tbl[1]  = '{1'b1, 7'h7F, 5'h00, 1'b0};  // row 0 blank
    tbl[2]  = '{1'b1, 7'h7E, 5'h1E, 1'b0};
    tbl[3]  = '{1'b1, 7'h7E, 5'h1E, 1'b0};
    tbl[4]  = '{1'b1, 7'h7E, 5'h1E, 1'b0};
    tbl[5]  = '{1'b1, 7'h7F, 5'h00, 1'b0};  // row 1 blank
    tbl[6]  = '{1'b1, 7'h7D, 5'h15, 1'b0};
    tbl[7]  = '{1'b1, 7'h7D, 5'h15, 1'b0};
    tbl[8]  = '{1'b1, 7'h7D, 5'h15, 1'b0};
    tbl[9]  = '{1'b1, 7'h7F, 5'h00, 1'b0};  // row 2 blank
    tbl[10] = '{1'b1, 7'h7B, 5'h15, 1'b0};

    pat_frame       = {7{5'b10101}};
    pat_frame[4:0]  = 5'b11110;
    pat_a           = pat_frame;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_row", row_a, 7'h7F);
    check("rst_col", col_a, 5'h00);
    check("rst_idx", idx_a, 3'd0);
    check("rst_fs",  fs_a,  1'b0);
    rst_n = 1'b1;
    repeat (3) cycle();

    // Full frame start, table driven
    for (int i = 0; i < 11; i++) begin
      en_a = tbl[i].en;
      cycle();
      check($sformatf("tbl%0d_row", i), row_a, tbl[i].row);
      check($sformatf("tbl%0d_col", i), col_a, tbl[i].col);
      check($sformatf("tbl%0d_fs", i),  fs_a,  tbl[i].fs);
    end

    // Frame period: next FRAME_START 29 cycles after the first
    since = 10;
    for (int k = 0; k < 100; k++) begin
      cycle();
      since++;
      if (fs_a) break;
    end
    check("frame_period", since, 29);

    // Pattern tearing: change PAT during row 3
    for (int k = 0; k < 100 && idx_a != 3'd3; k++) cycle();
    check("reach_row3", idx_a, 3'd3);
    pat_a = '1;
    for (int k = 0; k < 100 && !(idx_a == 3'd4 && row_a != 7'h7F); k++) cycle();
    check("tear_row4_row", row_a, 7'h6F);
    check("tear_row4_col", col_a, 5'h15);
    for (int k = 0; k < 100 && !fs_a; k++) cycle();
    check("tear_reload_fs", fs_a, 1'b1);
    for (int k = 0; k < 100 && row_a != 7'h7E; k++) cycle();
    check("new_row0_row", row_a, 7'h7E);
    check("new_row0_col", col_a, 5'h1F);

    // Enable drop during row 2
    for (int k = 0; k < 100 && !(idx_a == 3'd2 && row_a != 7'h7F); k++) cycle();
    check("reach_row2", row_a, 7'h7B);
    en_a = 1'b0;
    cycle();
    check("drop_row", row_a, 7'h7F);
    check("drop_col", col_a, 5'h00);
    en_a = 1'b1;
    cycle();
    check("reen_fs", fs_a, 1'b1);
    cycle();
    check("reen_idx", idx_a, 3'd0);
    check("reen_blank", row_a, 7'h7F);
    cycle();
    check("reen_row0", row_a, 7'h7E);

    // Asynchronous reset mid-scan
    for (int k = 0; k < 100 && row_a == 7'h7F; k++) cycle();
    check("pre_rst_driven", {31'd0, (row_a != 7'h7F)}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_row", row_a, 7'h7F);
    check("async_rst_col", col_a, 5'h00);
    check("async_rst_idx", idx_a, 3'd0);
    check("async_rst_fs",  fs_a,  1'b0);
    en_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) cycle();
    check("rel_en0_row", row_a, 7'h7F);

    // Zero blanking on u_b (DIV=2, BLANK=0): frame is 15 cycles
    pat_b = 35'h5_A5A5_A5A5;
    en_b  = 1'b1;
    cycle();
    check("b_load_fs", fs_b, 1'b1);
    blanks = 0;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (row_b == 7'h7F) blanks++;
      if (!fs_b) check("b_no_blank", {31'd0, (row_b != 7'h7F)}, 32'd1);
    end
    check("b_blanks_2frames", blanks, 2);
    en_b = 1'b0;
    cycle();

    // Random enable and pattern
    for (int k = 0; k < 10000; k++) begin
      en_a  = ($urandom_range(0, 15) != 0);
      en_b  = ($urandom_range(0, 15) != 0);
      pat_a = {$urandom(), $urandom()};
      pat_b = {$urandom(), $urandom()};
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
